sub_chain_ctrl: RTL

SUB_CHAIN_CTRL -- requirements
Module: sub_chain_ctrl

---
 rtl/sub_chain_ctrl_if.sv | 29 ++
 rtl/sub_chain_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/sub_chain_ctrl_if.sv
// Request/response handshake plus the byte-slice link to the external 8-bit
// borrow subtractor. The controller takes the slave side.
interface sub_chain_ctrl_if #(
   parameter int NBYTES = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   op_a;
   logic [8*NBYTES-1:0]   op_b;
   logic [7:0]            sub_a;
   logic [7:0]            sub_b;
   logic                  sub_bin;
   logic [7:0]            sub_diff;
   logic                  sub_bout;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   result;
   logic                  borrow;

   modport master (
      output in_valid, op_a, op_b, sub_diff, sub_bout, out_ready,
      input  in_ready, sub_a, sub_b, sub_bin, out_valid, result, borrow
   );

   modport slave (
      input  in_valid, op_a, op_b, sub_diff, sub_bout, out_ready,
      output in_ready, sub_a, sub_b, sub_bin, out_valid, result, borrow
   );
endinterface

// File: rtl/sub_chain_ctrl.sv
// Multi-byte subtraction sequenced one byte per cycle through an external
// 8-bit borrow subtractor, LSB first, with the borrow chained between bytes.
module sub_chain_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic            clk,
   input  logic            rst,
   sub_chain_ctrl_if.slave bus
);
   localparam int W  = 8 * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_result;
   logic [KW-1:0]   r_k;
   logic            r_bor;
   logic            r_borrow;
   logic            w_accept;
   logic            w_last;
   logic [KW+2:0]   w_bit;

   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_last   = (r_k == K_LAST);
   assign w_bit    = {r_k, 3'b000};

   // NOTE: non-blocking in every clocked block so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)  w_next_state = RUN;
         RUN:     if (w_last)        w_next_state = DONE;
         DONE:    if (bus.out_ready) w_next_state = IDLE;
         default:                    w_next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.sub_a     = 8'h00;
      bus.sub_b     = 8'h00;
      bus.sub_bin   = 1'b0;
      case (r_state)
         IDLE: bus.in_ready = 1'b1;
         RUN: begin
            bus.sub_a   = r_a[w_bit +: 8];
            bus.sub_b   = r_b[w_bit +: 8];
            bus.sub_bin = r_bor;
         end
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   // NOTE: operand registers carry no reset; they are always loaded on accept before use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= bus.op_a;
         r_b <= bus.op_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k      <= '0;
         r_bor    <= 1'b0;
         r_result <= '0;
         r_borrow <= 1'b0;
      end else if (w_accept) begin
         r_k   <= '0;
         r_bor <= 1'b0;
      end else if (r_state == RUN) begin
         r_result[w_bit +: 8] <= bus.sub_diff;
         r_bor                <= bus.sub_bout;
         if (w_last) begin
            r_k      <= '0;
            r_borrow <= bus.sub_bout;
         end else begin
            r_k <= r_k + 1'b1;
         end
      end
   end

   assign bus.result = r_result;
   assign bus.borrow = r_borrow;
endmodule
